// File: rtl/silver_pkg.sv
// silver_pkg: shared constants for the silver-flit scheduler.
package silver_pkg;
  localparam int FLIT_W = 11;
  localparam int EMPTY_BIT = 10;
  localparam int SILVER_BIT = 9;
  localparam logic [1:0] PORT_N = 2'd0;
  localparam logic [1:0] PORT_S = 2'd1;
  localparam logic [1:0] PORT_E = 2'd2;
  localparam logic [1:0] PORT_W = 2'd3;
  localparam logic [FLIT_W-1:0] EMPTY_FLIT = 11'h400;
  localparam logic [3:0] LFSR_SEED = 4'b1001;
endpackage

// File: rtl/silver_pick.sv
// silver_pick: 4-way rotating priority encoder; first set bit of occupied at or after start.
module silver_pick (
  input  logic [3:0] occupied,
  input  logic [1:0] start,
  output logic [3:0] grant_oh,
  output logic [1:0] grant_idx,
  output logic       any
);
  logic [3:0] rot;
  logic [1:0] off;
  always_comb begin
    rot = 4'({occupied, occupied} >> start);
    off = '0;
    for (int i = 3; i >= 0; i--) if (rot[i]) off = 2'(i);
    any = |occupied;
    grant_idx = start + off;
    grant_oh = any ? 4'(4'd1 << grant_idx) : '0;
  end
endmodule

// File: rtl/silver_sched.sv
// silver_sched: registered silver-flit scheduler with valid/ready output stage.
// SILVER_LFSR_EN selects the priority start from a 4-bit LFSR instead of the round-robin pointer.
module silver_sched
  import silver_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              silver_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] n_in,
  input  logic [FLIT_W-1:0] s_in,
  input  logic [FLIT_W-1:0] e_in,
  input  logic [FLIT_W-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLIT_W-1:0] n_out,
  output logic [FLIT_W-1:0] s_out,
  output logic [FLIT_W-1:0] e_out,
  output logic [FLIT_W-1:0] w_out,
  output logic [3:0]        silver_grant
);
  logic [3:0][FLIT_W-1:0] in_f, new_f, flit_d, flit_q;
  logic [3:0] occ, pick_oh, grant, grant_d, grant_q;
  logic [1:0] pick_idx, start;
  logic pick_any, xfer, out_valid_d, out_valid_q;
`ifdef SILVER_LFSR_EN
  logic [3:0] lfsr_d, lfsr_q;
  assign start = lfsr_q[1:0];
`else
  logic [1:0] ptr_d, ptr_q;
  assign start = ptr_q;
`endif
  assign in_f[PORT_N] = n_in;
  assign in_f[PORT_S] = s_in;
  assign in_f[PORT_E] = e_in;
  assign in_f[PORT_W] = w_in;
  silver_pick u_pick (
    .occupied (occ),
    .start    (start),
    .grant_oh (pick_oh),
    .grant_idx(pick_idx),
    .any      (pick_any)
  );
  assign in_ready = !out_valid_q || out_ready;
  always_comb begin
    for (int i = 0; i < 4; i++) occ[i] = !in_f[i][EMPTY_BIT];
    grant = (silver_en && pick_any) ? pick_oh : '0;
    new_f = in_f;
    for (int i = 0; i < 4; i++) new_f[i][SILVER_BIT] = grant[i];
    xfer = in_valid && in_ready;
    flit_d = xfer ? new_f : flit_q;
    grant_d = xfer ? grant : grant_q;
    out_valid_d = xfer || (out_valid_q && !out_ready);
`ifdef SILVER_LFSR_EN
    lfsr_d = xfer ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;
`else
    ptr_d = (xfer && |grant) ? pick_idx + 2'd1 : ptr_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      flit_q <= {4{EMPTY_FLIT}};
      grant_q <= '0;
`ifdef SILVER_LFSR_EN
      lfsr_q <= LFSR_SEED;
`else
      ptr_q <= '0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      flit_q <= flit_d;
      grant_q <= grant_d;
`ifdef SILVER_LFSR_EN
      lfsr_q <= lfsr_d;
`else
      ptr_q <= ptr_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign n_out = flit_q[PORT_N];
  assign s_out = flit_q[PORT_S];
  assign e_out = flit_q[PORT_E];
  assign w_out = flit_q[PORT_W];
  assign silver_grant = grant_q;
endmodule
